mips32i_lsu: RTL and testbench

Load/store unit on the CPU side of the data-memory interface. It accepts one load or store operation at a time from the execute stage and validates alignment and size. It drives the byte/half/word memory request (`mem_wt_en`, `mem_rd_en`, `mem_size_sel`, `address_out`, `data_out`) and waits for a memory acknowledge. It then returns the sign- or zero-extended load result, or an error code, to write-back.

---
 rtl/mips32i_lsu.sv | 187 ++++++++++++++++++
 tb/tb_mips32i_lsu.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32i_lsu.sv
// mips32i_lsu: load/store unit between the execute stage and the data-memory port.
// Takes one operation at a time, rejects illegal or misaligned accesses, drives a
// byte/half/word request, waits for mem_ack (with an optional timeout) and returns
// the extended load data or an error code as a one-cycle strobe.
//
// Handshake: an op is accepted on a rising edge where op_valid && op_ready; op_ready
// is high only in IDLE. The memory request (mem_rd_en/mem_wt_en with address, size
// and data) is held stable until the edge where mem_ack is sampled high. The result
// is presented with resp_valid for exactly one cycle; there is no back-pressure on it.
module mips32i_lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_store,
    input  logic [1:0]  op_size,
    input  logic        op_unsigned,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        mem_rd_en,
    output logic        mem_wt_en,
    output logic [1:0]  mem_size_sel,
    output logic [31:0] address_out,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    input  logic        mem_ack,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    state_t      state_q;
    logic [31:0] wait_q;
    logic        store_q;
    logic [1:0]  size_q;
    logic        unsigned_q;

    logic        op_ready_q;
    logic        rd_en_q;
    logic        wt_en_q;
    logic [1:0]  size_sel_q;
    logic [31:0] addr_q;
    logic [31:0] dout_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    logic [1:0]  resp_err_q;

    logic        illegal_d;
    logic [31:0] wdata_d;
    logic [31:0] load_d;
    logic [31:0] wait_d;
    logic        timeout_d;

    // Decode of the incoming op, extension of the returned data and timeout detection.
    always_comb begin
        illegal_d = 1'b0;
        wdata_d   = op_wdata;
        load_d    = data_in;
        wait_d    = wait_q + 32'd1;
        timeout_d = 1'b0;

        case (op_size)
            2'b00:   wdata_d = {24'b0, op_wdata[7:0]};
            2'b01:   begin
                wdata_d   = {16'b0, op_wdata[15:0]};
                illegal_d = op_addr[0];
            end
            2'b11:   illegal_d = (op_addr[1:0] != 2'b00);
            default: illegal_d = 1'b1;
        endcase

        case (size_q)
            2'b00:   load_d = unsigned_q ? {24'b0, data_in[7:0]}
                                         : {{24{data_in[7]}}, data_in[7:0]};
            2'b01:   load_d = unsigned_q ? {16'b0, data_in[15:0]}
                                         : {{16{data_in[15]}}, data_in[15:0]};
            default: load_d = data_in;
        endcase

        // The ack check is done first in the FSM, so ack on the timeout edge wins.
        timeout_d = (TIMEOUT != 0) && (wait_d == TIMEOUT);
    end

    // Control FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wait_q       <= 32'd0;
            store_q      <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            op_ready_q   <= 1'b1;
            rd_en_q      <= 1'b0;
            wt_en_q      <= 1'b0;
            size_sel_q   <= 2'b00;
            addr_q       <= 32'd0;
            dout_q       <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_err_q   <= ERR_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        store_q    <= op_store;
                        size_q     <= op_size;
                        unsigned_q <= op_unsigned;
                        size_sel_q <= op_size;
                        addr_q     <= op_addr;
                        dout_q     <= op_store ? wdata_d : 32'd0;
                        wait_q     <= 32'd0;
                        op_ready_q <= 1'b0;
                        if (illegal_d) begin
                            // Rejected without touching memory.
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= 32'd0;
                            resp_err_q   <= ERR_ALIGN;
                        end else begin
                            state_q <= S_REQ;
                            rd_en_q <= ~op_store;
                            wt_en_q <= op_store;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        state_q      <= S_RESP;
                        rd_en_q      <= 1'b0;
                        wt_en_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= store_q ? 32'd0 : load_d;
                        resp_err_q   <= ERR_OK;
                    end else if (timeout_d) begin
                        state_q      <= S_RESP;
                        rd_en_q      <= 1'b0;
                        wt_en_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= 32'd0;
                        resp_err_q   <= ERR_TIMEOUT;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    op_ready_q   <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_data_q  <= 32'd0;
                    resp_err_q   <= ERR_OK;
                end
                default: begin
                    state_q      <= S_IDLE;
                    op_ready_q   <= 1'b1;
                    rd_en_q      <= 1'b0;
                    wt_en_q      <= 1'b0;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready     = op_ready_q;
    assign mem_rd_en    = rd_en_q;
    assign mem_wt_en    = wt_en_q;
    assign mem_size_sel = size_sel_q;
    assign address_out  = addr_q;
    assign data_out     = dout_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_err     = resp_err_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_mips32i_lsu.sv
// Bench for mips32i_lsu: timeline model of each operation plus an expected-response
// queue, checked by one compare process on every falling edge.
module tb_mips32i_lsu;

  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic        op_store = 1'b0;
  logic [1:0]  op_size = 2'b00;
  logic        op_unsigned = 1'b0;
  logic [31:0] op_addr = 32'd0;
  logic [31:0] op_wdata = 32'd0;
  logic        mem_rd_en;
  logic        mem_wt_en;
  logic [1:0]  mem_size_sel;
  logic [31:0] address_out;
  logic [31:0] data_out;
  logic [31:0] data_in = 32'd0;
  logic        mem_ack = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;
  logic [1:0]  state_dbg;

  mips32i_lsu #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_store(op_store),
    .op_size(op_size), .op_unsigned(op_unsigned), .op_addr(op_addr),
    .op_wdata(op_wdata), .mem_rd_en(mem_rd_en), .mem_wt_en(mem_wt_en),
    .mem_size_sel(mem_size_sel), .address_out(address_out), .data_out(data_out),
    .data_in(data_in), .mem_ack(mem_ack), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .state_dbg(state_dbg)
  );

  // ---------------- model state ----------------
  int total = 0;
  int bad = 0;
  logic chk_on = 1'b0;
  logic exp_ready = 1'b1, exp_rd = 1'b0, exp_wt = 1'b0, exp_rv = 1'b0;
  logic [31:0] exp_addr = 32'd0, exp_dout = 32'd0;
  logic [1:0] exp_size = 2'b00;
  logic [33:0] exp_q[$];

  // observations for hand-computed checks
  int acc_cyc = 0, resp_cyc = 0, en_cnt = 0;
  logic [31:0] last_rdata = 32'd0, seen_addr = 32'd0, seen_dout = 32'd0;
  logic [1:0] last_err = 2'b00, seen_size = 2'b00;
  logic seen_wt = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic is_illegal(input logic [1:0] sz, input logic [31:0] ad);
    if (sz == 2'b10) return 1'b1;
    if (sz == 2'b01 && (ad % 2) != 0) return 1'b1;
    if (sz == 2'b11 && (ad % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] store_mask(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'b00) return wd % 256;
    if (sz == 2'b01) return wd % 65536;
    return wd;
  endfunction

  // {err, data} the write-back stage must receive
  function automatic logic [33:0] model_resp(input logic st, input logic [1:0] sz, input logic un,
                                             input logic [31:0] ad, input logic [31:0] rd,
                                             input logic to);
    logic [31:0] v;
    if (is_illegal(sz, ad)) return {2'b01, 32'd0};
    if (to) return {2'b10, 32'd0};
    if (st) return {2'b00, 32'd0};
    if (sz == 2'b00) begin
      v = rd % 256;
      if (!un && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = rd % 65536;
      if (!un && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return {2'b00, v};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("op_ready", {31'd0, op_ready}, {31'd0, exp_ready});
      chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, exp_rd});
      chk("mem_wt_en", {31'd0, mem_wt_en}, {31'd0, exp_wt});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_rv});
      if (exp_rd || exp_wt) begin
        chk("address_out", address_out, exp_addr);
        chk("mem_size_sel", {30'd0, mem_size_sel}, {30'd0, exp_size});
        if (exp_wt) chk("data_out", data_out, exp_dout);
      end
      if (mem_rd_en || mem_wt_en) begin
        en_cnt++;
        seen_addr = address_out;
        seen_dout = data_out;
        seen_size = mem_size_sel;
        seen_wt   = mem_wt_en;
      end
      if (resp_valid) begin
        resp_cyc   = cyc;
        last_rdata = resp_data;
        last_err   = resp_err;
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", {31'd0, resp_valid}, 32'd0);
        end else begin
          logic [33:0] e;
          e = exp_q.pop_front();
          chk("resp_data", resp_data, e[31:0]);
          chk("resp_err", {30'd0, resp_err}, {30'd0, e[33:32]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic noise_ops();
    op_valid    = 1'($urandom_range(0, 1));
    op_store    = 1'($urandom_range(0, 1));
    op_size     = 2'($urandom_range(0, 3));
    op_unsigned = 1'($urandom_range(0, 1));
    op_addr     = $urandom;
    op_wdata    = $urandom;
  endtask

  task automatic set_idle_model();
    exp_ready = 1'b1; exp_rd = 1'b0; exp_wt = 1'b0; exp_rv = 1'b0;
  endtask

  // Precondition: called just after a rising edge with the DUT idle.
  task automatic run_op(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input logic [31:0] rd, input int dly);
    logic ill, to;
    int n_en;
    ill  = is_illegal(sz, ad);
    to   = !ill && TMO != 0 && dly >= TMO;
    n_en = to ? TMO : dly + 1;
    op_valid = 1'b1; op_store = st; op_size = sz; op_unsigned = un;
    op_addr = ad; op_wdata = wd;
    mem_ack = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    acc_cyc = cyc; en_cnt = 0; seen_wt = 1'b0;
    exp_q.push_back(model_resp(st, sz, un, ad, rd, to));
    noise_ops();
    exp_ready = 1'b0;
    if (ill) begin
      exp_rv = 1'b1;
    end else begin
      exp_rd = !st; exp_wt = st; exp_addr = ad; exp_size = sz;
      exp_dout = store_mask(sz, wd);
      for (int k = 0; k < n_en; k++) begin
        mem_ack = (k == dly);
        data_in = (k == dly) ? rd : $urandom;
        @(posedge clk); #1;
        noise_ops();
      end
      exp_rd = 1'b0; exp_wt = 1'b0; exp_rv = 1'b1;
    end
    mem_ack = 1'($urandom_range(0, 1));
    data_in = $urandom;
    @(posedge clk); #1;
    set_idle_model();
    op_valid = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      data_in = $urandom;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // reset values
    @(negedge clk);
    chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_wt_en", {31'd0, mem_wt_en}, 32'd0);
    chk("rst_size_sel", {30'd0, mem_size_sel}, 32'd0);
    chk("rst_address", address_out, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", {30'd0, resp_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle_model();
    chk_on = 1'b1;
    idle_cycles(2);

    // LB signed, ack in first REQ cycle
    run_op(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h0000_00F0, 0);
    chk("lb_data", last_rdata, 32'hFFFF_FFF0);
    chk("lb_err", {30'd0, last_err}, 32'd0);
    chk("lb_addr", seen_addr, 32'h103);
    chk("lb_latency", resp_cyc - acc_cyc + 1, 32'd2);
    chk("lb_en_cycles", en_cnt, 32'd1);

    // LHU with 3 wait cycles (ack lands on the timeout edge)
    run_op(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000_8001, 3);
    chk("lhu_data", last_rdata, 32'h0000_8001);
    chk("lhu_err", {30'd0, last_err}, 32'd0);
    chk("lhu_rd_cycles", en_cnt, 32'd4);

    // SB
    run_op(1'b1, 2'b00, 1'b0, 32'h41, 32'hDEAD_BEEF, 32'h0, 1);
    chk("sb_data_out", seen_dout, 32'h0000_00EF);
    chk("sb_wt_en", {31'd0, seen_wt}, 32'd1);
    chk("sb_size", {30'd0, seen_size}, 32'd0);
    chk("sb_resp_data", last_rdata, 32'd0);

    // misaligned / illegal
    run_op(1'b0, 2'b11, 1'b0, 32'h6, 32'h0, 32'h0, 0);
    chk("mis_word_err", {30'd0, last_err}, 32'd1);
    chk("mis_word_lat", resp_cyc - acc_cyc + 1, 32'd1);
    chk("mis_word_en", en_cnt, 32'd0);
    run_op(1'b1, 2'b01, 1'b0, 32'h7, 32'h1234, 32'h0, 0);
    chk("mis_half_err", {30'd0, last_err}, 32'd1);
    chk("mis_half_en", en_cnt, 32'd0);
    run_op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h0, 0);
    chk("bad_size_err", {30'd0, last_err}, 32'd1);
    chk("bad_size_en", en_cnt, 32'd0);

    // timeout, then a normal op
    run_op(1'b0, 2'b11, 1'b0, 32'h200, 32'h0, 32'h1111_2222, 30);
    chk("to_rd_cycles", en_cnt, 32'd4);
    chk("to_err", {30'd0, last_err}, 32'd2);
    chk("to_data", last_rdata, 32'd0);
    run_op(1'b0, 2'b11, 1'b0, 32'h204, 32'h0, 32'h8765_4321, 2);
    chk("after_to_data", last_rdata, 32'h8765_4321);
    chk("after_to_err", {30'd0, last_err}, 32'd0);

    // reset during the 2nd wait cycle of an SW
    op_valid = 1'b1; op_store = 1'b1; op_size = 2'b11; op_unsigned = 1'b0;
    op_addr = 32'h300; op_wdata = 32'hCAFE_F00D; mem_ack = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    exp_ready = 1'b0; exp_wt = 1'b1; exp_addr = 32'h300; exp_size = 2'b11;
    exp_dout = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk("pre_rst_wt_en", {31'd0, mem_wt_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_wt_en", {31'd0, mem_wt_en}, 32'd0);
    chk("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("async_rst_op_ready", {31'd0, op_ready}, 32'd1);
    set_idle_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(3);
    chk("rst_no_stale_resp", exp_q.size(), 32'd0);
    run_op(1'b0, 2'b00, 1'b1, 32'h305, 32'h0, 32'hFFFF_FF80, 0);
    chk("post_rst_lbu", last_rdata, 32'h0000_0080);

    // randomized ops
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ad;
      ad = $urandom;
      if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             ad, $urandom, $urandom, int'($urandom_range(0, 5)));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // overall time limit
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
